tone_sequencer: RTL and testbench
=================================

TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent tone channels, range 1..16.
REQ-002 Parameter DUR_W, default 16: width of the per-channel duration counter, in ticks.
REQ-003 Parameter TICK_DIV, default 25000: clk cycles per duration tick, minimum 2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 we  input  1  write strobe, one write accepted per asserted cycle.
REQ-007 addr  input  max(1,$clog2(CHANNELS))  target channel index.
REQ-008 wdata  input  32  [6:0] noteID, [23:8] duration D (low DUR_W bits used), [31] broadcast; other bits ignored.
REQ-009 lineOut  output  CHANNELS  per-channel square-wave output.
REQ-010 busy  output  CHANNELS  channel currently playing.
REQ-011 done  output  CHANNELS  one-cycle pulse on natural note expiry.

Function
REQ-012 Accept: we=1 at edge W writes channel addr; if wdata[31]=1 all channels are written; addr>=CHANNELS with wdata[31]=0 is ignored.
REQ-013 Decode: octave = noteID/12, note = noteID%12; note divider table 511,482,455,430,405,383,361,341,322,303,286,270 for notes 0..11; octave reload R = 1023>>octave.
REQ-014 Per channel states: IDLE, PLAY; IDLE is the reset state.
REQ-015 Write with noteID!=0: at edge W enter PLAY, load note counter with divider, octave counter with R, prescaler with TICK_DIV-1, duration counter with D, and drive lineOut to 0.
REQ-016 Write with noteID=0: enter IDLE at edge W, lineOut to 0, no done pulse.
REQ-017 Tone: note counter reloads divider on zero, else decrements; octave counter steps once per note-counter zero; lineOut toggles when both are zero in PLAY; half-period H=(divider+1)*(R+1) cycles; first toggle visible after edge W+H.
REQ-018 Duration: D=0 plays until rewritten; D>0 expires at edge W+D*TICK_DIV: enter IDLE, lineOut 0, done=1 for exactly one cycle.
REQ-019 Write to a PLAY channel restarts it per REQ-015/016 (phase and duration discarded).
REQ-020 Write coinciding with expiry edge: write wins, done stays 0.
REQ-021 busy = (state==PLAY); in IDLE lineOut is held 0 and counters are frozen.
REQ-022 Channels are fully independent; writing one never disturbs another.

Reset
REQ-023 reset=1 at an edge: all channels IDLE, lineOut=0, busy=0, done=0, all counters 0; dominates a simultaneous we.
REQ-024 Reset mid-note: outputs 0 at the first edge with reset=1; no done pulse generated.

Structure
REQ-025 Shared package tone_pkg holds the 12-entry divider table, octave base constant 1023, and the wdata field positions.
REQ-026 One sub-module tone_channel (decode, counters, FSM for one channel), instantiated CHANNELS times by generate; top-level does address decode and broadcast only.
REQ-027 Division by 12 is combinational on the registered 7-bit noteID; no multi-cycle divider.

Verification (TICK_DIV=4 in bench)
REQ-028 Write ch0 noteID=60, D=0 -> lineOut[0] toggles every 16384 cycles, first toggle after W+16384, busy[0]=1 indefinitely.
REQ-029 Write ch1 noteID=127 (octave 10, note 7), D=3 -> half-period 342 cycles; busy[1] falls and done[1] pulses one cycle at W+12, lineOut[1]=0 thereafter.
REQ-030 Broadcast write noteID=12, D=0, then ch2 noteID=0 -> all channels H=512*512 cycles; ch2 goes IDLE at its write edge, others unaffected, no done.
REQ-031 Ch3 D=2, rewrite ch3 on exact expiry edge W+8 -> no done pulse, busy stays 1, new duration counted from rewrite.
REQ-032 Reset asserted mid-play on all channels -> lineOut, busy, done all 0 at next edge; write with addr=CHANNELS (CHANNELS<power of 2), wdata[31]=0 -> no channel changes.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared constants for the tone sequencer: wdata field layout, note divider
// table, octave base, channel state encodings and the note decode helper.
package tone_pkg;

    // wdata field positions
    localparam int NOTE_LSB    = 0;
    localparam int NOTE_W      = 7;
    localparam int DUR_LSB     = 8;
    localparam int DUR_FIELD_W = 16;
    localparam int BCAST_BIT   = 31;

    // Octave 0 reload value; higher octaves halve it by right shift
    localparam logic [9:0] OCT_BASE = 10'd1023;

    // Note-counter reload value for semitones 0..11 within an octave
    localparam logic [8:0] NOTE_DIV [12] = '{
        9'd511, 9'd482, 9'd455, 9'd430, 9'd405, 9'd383,
        9'd361, 9'd341, 9'd322, 9'd303, 9'd286, 9'd270
    };

    // Channel FSM encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    typedef struct packed {
        logic [8:0] divider;
        logic [9:0] reload;
    } tone_decode_t;

    // Split a 7-bit note ID into semitone divider and octave reload
    function automatic tone_decode_t decode_note(input logic [NOTE_W-1:0] id);
        tone_decode_t res;
        logic [3:0]   semi;
        semi        = 4'(id % 7'd12);
        res.divider = NOTE_DIV[semi];
        res.reload  = OCT_BASE >> (id / 7'd12);
        return res;
    endfunction

endpackage

// File: rtl/tone_channel.sv
// One tone channel: note decode, note/octave/prescaler/duration counters and
// the IDLE/PLAY state machine driving a square wave.
module tone_channel
    import tone_pkg::*;
#(
    parameter int DUR_W    = 16,
    parameter int TICK_DIV = 25000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr,
    input  logic [NOTE_W-1:0]      note_id,
    input  logic [DUR_FIELD_W-1:0] dur,
    output logic                   line,
    output logic                   busy,
    output logic                   done
);

    localparam int             PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_LOAD = PW'(TICK_DIV - 1);

    logic [0:0]        state_reg;
    logic [NOTE_W-1:0] note_id_reg;
    logic [8:0]        note_cnt_reg;
    logic [9:0]        oct_cnt_reg;
    logic [PW-1:0]     presc_reg;
    logic [DUR_W-1:0]  dur_reg;
    logic              line_reg;
    logic              done_reg;

    logic [NOTE_W-1:0] id_sel;
    tone_decode_t      dec;
    logic [DUR_W-1:0]  dur_load;

    // A single decoder serves both the load on write and the reloads while
    // playing, so the incoming ID is selected during a write cycle.
    assign id_sel   = wr ? note_id : note_id_reg;
    assign dec      = decode_note(id_sel);
    assign dur_load = DUR_W'(dur);

    // Channel FSM and counters; a write always takes priority over expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            note_id_reg  <= '0;
            note_cnt_reg <= '0;
            oct_cnt_reg  <= '0;
            presc_reg    <= '0;
            dur_reg      <= '0;
            line_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (wr) begin
                note_id_reg <= note_id;
                line_reg    <= 1'b0;
                if (note_id != '0) begin
                    state_reg    <= ST_PLAY;
                    note_cnt_reg <= dec.divider;
                    oct_cnt_reg  <= dec.reload;
                    presc_reg    <= PRESC_LOAD;
                    dur_reg      <= dur_load;
                end else begin
                    state_reg <= ST_IDLE;
                end
            end else if (state_reg == ST_PLAY) begin
                // Tone generation: toggle when both note and octave counters hit zero
                if (note_cnt_reg == '0) begin
                    note_cnt_reg <= dec.divider;
                    if (oct_cnt_reg == '0) begin
                        oct_cnt_reg <= dec.reload;
                        line_reg    <= ~line_reg;
                    end else begin
                        oct_cnt_reg <= oct_cnt_reg - 10'd1;
                    end
                end else begin
                    note_cnt_reg <= note_cnt_reg - 9'd1;
                end
                // Duration: a zero duration never expires
                if (presc_reg == '0) begin
                    presc_reg <= PRESC_LOAD;
                    if (dur_reg == DUR_W'(1)) begin
                        state_reg <= ST_IDLE;
                        line_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        dur_reg   <= '0;
                    end else if (dur_reg != '0) begin
                        dur_reg <= dur_reg - DUR_W'(1);
                    end
                end else begin
                    presc_reg <= presc_reg - PW'(1);
                end
            end
        end
    end

    assign line = line_reg;
    assign busy = (state_reg == ST_PLAY);
    assign done = done_reg;

endmodule

// File: rtl/tone_sequencer.sv
// Multi-channel tone sequencer: address decode and broadcast fan-out of the
// write strobe to CHANNELS independent tone channels.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DUR_W    = 16,
    parameter int TICK_DIV = 25000
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      we,
    input  logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0] addr,
    input  logic [31:0]                               wdata,
    output logic [CHANNELS-1:0]                       lineOut,
    output logic [CHANNELS-1:0]                       busy,
    output logic [CHANNELS-1:0]                       done
);

    localparam int AW = $clog2(CHANNELS > 1 ? CHANNELS : 2);

    logic [NOTE_W-1:0]      note_id;
    logic [DUR_FIELD_W-1:0] dur;
    logic                   bcast;
    logic                   unused_wdata;

    assign note_id      = wdata[NOTE_LSB +: NOTE_W];
    assign dur          = wdata[DUR_LSB +: DUR_FIELD_W];
    assign bcast        = wdata[BCAST_BIT];
    assign unused_wdata = ^{wdata[BCAST_BIT-1:DUR_LSB+DUR_FIELD_W], wdata[DUR_LSB-1:NOTE_W]};

    // Out-of-range addresses match no channel, so such writes are dropped.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic sel;
        assign sel = we && (bcast || (addr == AW'(gi)));

        tone_channel #(
            .DUR_W    (DUR_W),
            .TICK_DIV (TICK_DIV)
        ) u_channel (
            .clk     (clk),
            .reset   (reset),
            .wr      (sel),
            .note_id (note_id),
            .dur     (dur),
            .line    (lineOut[gi]),
            .busy    (busy[gi]),
            .done    (done[gi])
        );
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: expected toggle/done events are queued
// as stimulus is written and matched by a monitor as the DUT produces them.
module tb_tone_sequencer;

    localparam int NCH      = 5;
    localparam int DUR_W    = 16;
    localparam int TICK_DIV = 4;
    localparam int AW       = 3;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic            we    = 1'b0;
    logic [AW-1:0]   addr  = '0;
    logic [31:0]     wdata = '0;
    logic [NCH-1:0]  lineOut;
    logic [NCH-1:0]  busy;
    logic [NCH-1:0]  done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;
    logic [NCH-1:0] prev_line = '0;
    bit exp_line [NCH];

    typedef struct {
        int ch;
        int cyc;
        bit is_done;
    } ev_t;
    ev_t sb[$];

    tone_sequencer #(
        .CHANNELS (NCH),
        .DUR_W    (DUR_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .lineOut (lineOut),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mkw(input bit bc, input int note, input int dur);
        logic [31:0] w;
        w       = '0;
        w[31]   = bc;
        w[6:0]  = note[6:0];
        w[23:8] = dur[15:0];
        return w;
    endfunction

    task automatic push_tog(input int c, input int at);
        ev_t e;
        e.ch = c; e.cyc = at; e.is_done = 1'b0;
        sb.push_back(e);
        exp_line[c] = ~exp_line[c];
    endtask

    task automatic push_done(input int c, input int at);
        ev_t e;
        e.ch = c; e.cyc = at; e.is_done = 1'b1;
        sb.push_back(e);
        exp_line[c] = 1'b0;
    endtask

    // A write forces lineOut low, which is a visible falling edge if it was high
    task automatic note_write(input int c, input int w);
        if (exp_line[c]) push_tog(c, w);
    endtask

    task automatic match_event(input int c, input bit is_done);
        int idx;
        int exp_cyc;
        bit exp_kind;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].ch == c) begin
                idx = i;
                break;
            end
        end
        exp_cyc  = -1;
        exp_kind = is_done;
        if (idx >= 0) begin
            exp_cyc  = sb[idx].cyc;
            exp_kind = sb[idx].is_done;
            sb.delete(idx);
        end
        $display("event cyc=%0d ch%0d %s", cyc, c, is_done ? "done" : "toggle");
        chk($sformatf("ch%0d_event_cyc", c), cyc, exp_cyc);
        chk($sformatf("ch%0d_event_kind", c), {31'd0, is_done}, {31'd0, exp_kind});
    endtask

    // Event monitor: every lineOut edge and every done-high cycle is a transaction
    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < NCH; c++) begin
                if (lineOut[c] !== prev_line[c]) match_event(c, 1'b0);
                if (done[c] !== 1'b0) match_event(c, 1'b1);
            end
        end
        prev_line <= lineOut;
    end

    task automatic do_write(input int a, input logic [31:0] d, output int w);
        @(negedge clk);
        w     = cyc + 1;
        we    = 1'b1;
        addr  = AW'(a);
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        $display("write cyc=%0d addr=%0d wdata=0x%08h", w, a, d);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int w0, w1, w2, w3, w4, w5, wz, wx, wb, wq, wc, wq2, wr;
        for (int c = 0; c < NCH; c++) exp_line[c] = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_line", lineOut, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        // ch0 note 60 continuous: half-period 512*32
        do_write(0, mkw(1'b0, 60, 0), w0);
        note_write(0, w0);
        push_tog(0, w0 + 16384);
        push_tog(0, w0 + 32768);
        chk("ch0_busy", busy[0], 1);

        // ch1 note 127, D=3: expires at W+12 before any toggle
        do_write(1, mkw(1'b0, 127, 3), w1);
        note_write(1, w1);
        push_done(1, w1 + 12);
        wait_until(w1 + 11);
        chk("ch1_busy_pre_expiry", busy[1], 1);
        wait_until(w1 + 12);
        chk("ch1_busy_at_expiry", busy[1], 0);
        chk("ch1_line_at_expiry", lineOut[1], 0);
        wait_until(w1 + 13);
        chk("ch1_done_one_cycle", done[1], 0);

        // ch1 note 127, D=200: two toggles of 342 then expiry at W+800
        do_write(1, mkw(1'b0, 127, 200), w2);
        note_write(1, w2);
        push_tog(1, w2 + 342);
        push_tog(1, w2 + 684);
        push_done(1, w2 + 800);

        // ch2 note 119 continuous: half-period 271*2
        do_write(2, mkw(1'b0, 119, 0), w3);
        note_write(2, w3);
        push_tog(2, w3 + 542);
        push_tog(2, w3 + 1084);
        push_tog(2, w3 + 1626);

        // ch3 D=2 rewritten on its exact expiry edge
        do_write(3, mkw(1'b0, 120, 2), w4);
        note_write(3, w4);
        repeat (7) @(posedge clk);
        do_write(3, mkw(1'b0, 120, 2), w5);
        note_write(3, w5);
        chk("ch3_busy_on_rewrite", busy[3], 1);
        chk("ch3_done_on_rewrite", done[3], 0);
        push_done(3, w5 + 8);
        wait_until(w5 + 7);
        chk("ch3_busy_pre_new_expiry", busy[3], 1);
        wait_until(w5 + 8);
        chk("ch3_busy_new_expiry", busy[3], 0);

        // ch2 stopped with noteID 0 while its line is high
        wait_until(w3 + 1700);
        do_write(2, mkw(1'b0, 0, 0), wz);
        note_write(2, wz);
        chk("ch2_idle_after_stop", busy[2], 0);
        chk("busy_after_stop", busy, 5'b00001);

        // Out-of-range addresses without broadcast change nothing
        do_write(5, mkw(1'b0, 60, 0), wx);
        chk("oob5_busy", busy, 5'b00001);
        do_write(7, mkw(1'b0, 60, 3), wx);
        chk("oob7_busy", busy, 5'b00001);

        // Broadcast noteID 12, then silence ch2 only
        wait_until(w0 + 32768 + 20);
        do_write(0, mkw(1'b1, 12, 0), wb);
        for (int c = 0; c < NCH; c++) note_write(c, wb);
        chk("bcast_busy", busy, 5'b11111);
        do_write(2, mkw(1'b0, 0, 0), wq);
        note_write(2, wq);
        chk("bcast_ch2_off_busy", busy, 5'b11011);

        // Get ch4 line high, restart ch2, then reset mid-play
        do_write(4, mkw(1'b0, 127, 0), wc);
        note_write(4, wc);
        push_tog(4, wc + 342);
        do_write(2, mkw(1'b0, 12, 0), wq2);
        note_write(2, wq2);
        chk("all_playing_busy", busy, 5'b11111);
        wait_until(wc + 400);
        chk("ch4_line_high_pre_reset", lineOut[4], 1);

        @(negedge clk);
        wr    = cyc + 1;
        reset = 1'b1;
        we    = 1'b1;
        addr  = '0;
        wdata = mkw(1'b1, 60, 5);
        for (int c = 0; c < NCH; c++) note_write(c, wr);
        @(posedge clk);
        #1;
        we = 1'b0;
        $display("reset cyc=%0d with broadcast write", wr);
        chk("midrst_line", lineOut, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;

        repeat (600) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_line", lineOut, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
